// File: rtl/mux_scan_sampler_if.sv
// Bus bundle for mux_scan_sampler: the scan request side and the
// mux select/return side. The master modport belongs to whatever issues scan
// requests and closes the loop through the mux. The slave modport belongs to
// the sampler.
interface mux_scan_sampler_if;
   logic       start;
   logic [3:0] mask;
   logic       mux_out;
   logic [1:0] sel;
   logic [3:0] sample;
   logic       valid;
   logic       busy;

   modport master (
      output start,
      output mask,
      output mux_out,
      input  sel,
      input  sample,
      input  valid,
      input  busy
   );

   modport slave (
      input  start,
      input  mask,
      input  mux_out,
      output sel,
      output sample,
      output valid,
      output busy
   );
endinterface

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: sweeps a 4:1 mux through the enabled channels in
// ascending order. Each channel is held for DWELL cycles and then sampled into
// a per-channel result bit. A completed scan is reported with a one-cycle
// valid pulse.
module mux_scan_sampler #(
   parameter int DWELL = 4,
   parameter int CW    = 8
) (
   input logic                clk,
   input logic                reset_n,
   mux_scan_sampler_if.slave  bus
);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   state_t        state_q, state_d;
   logic [3:0]    m_q, m_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    sample_q, sample_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;

   logic [2:0]    first_ch;
   logic [2:0]    next_ch;

   // Finds the lowest set bit of v at index >= from. The result is
   // {found, index}. A from value of 4 finds nothing.
   function automatic logic [2:0] lowest_from(input logic [3:0] v,
                                              input logic [2:0] from);
      logic [2:0] r;
      r = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!r[2] && (i >= 32'(from)) && v[i]) begin
            r = {1'b1, i[1:0]};
         end
      end
      return r;
   endfunction

   // Picks the first channel of a new scan and the channel after the current one.
   always_comb begin
      first_ch = lowest_from(bus.mask, 3'd0);
      next_ch  = lowest_from(m_q, {1'b0, sel_q} + 3'd1);
   end

   // Next-state and next-register logic. valid defaults low, so it is a pulse.
   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               sample_d = '0;
               if (bus.mask != 4'b0000) begin
                  m_d     = bus.mask;
                  sel_d   = first_ch[1:0];
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = SCAN;
               end else begin
                  // An empty mask completes immediately with a cleared result.
                  valid_d = 1'b1;
               end
            end
         end

         SCAN: begin
            if (cnt_q != LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               sample_d[sel_q] = bus.mux_out;
               if (next_ch[2]) begin
                  sel_d = next_ch[1:0];
                  cnt_d = '0;
               end else begin
                  busy_d  = 1'b0;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         m_q      <= '0;
         cnt_q    <= '0;
         sel_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.sel    = sel_q;
   assign bus.sample = sample_q;
   assign bus.valid  = valid_q;
   assign bus.busy   = busy_q;

   // While scanning, the presented channel is always an enabled one.
   a_sel_enabled: assert property (@(posedge clk) disable iff (!reset_n)
      busy_q |-> m_q[sel_q]);

   // A completion pulse never overlaps an active scan.
   a_valid_not_busy: assert property (@(posedge clk) disable iff (!reset_n)
      busy_q |-> !valid_q);

   // The dwell counter never runs past the capture point.
   a_cnt_range: assert property (@(posedge clk) disable iff (!reset_n)
      cnt_q <= LAST);

endmodule
